cmos_capture_16b: RTL
=====================

CMOS_CAPTURE_16B -- requirements
Module: cmos_capture_16b

Interface
REQ-001 Parameter: FRAME_SKIP, default 10, count of whole frames discarded after reset before output starts (0..255).
REQ-002 Parameter: H_PIX, default 640, expected pixels per line, used for line-length checking (1..4095).
REQ-003 Parameter: HI_FIRST, default 1; 1 means the first byte of each pair is pixel[15:8], 0 means it is pixel[7:0].
REQ-004 Port: pixel_clk, input, 1, sensor PCLK; sole clock.
REQ-005 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port: cmos_data, input, 8, DVP byte bus, sampled on rising pixel_clk.
REQ-007 Port: cmos_href, input, 1, line-valid, active high.
REQ-008 Port: cmos_vsync, input, 1, frame sync, active high.
REQ-009 Port: pdata_o, output, 16, RGB565 pixel feeding the downstream mix stage's pdata_i.
REQ-010 Port: de_o, output, 1, one-cycle strobe per valid pixel.
REQ-011 Port: vs_o, output, 1, vsync aligned to pdata_o.
REQ-012 Port: frame_cnt, output, 8, wrapping count of frames passed to output.
REQ-013 Port: line_err, output, 1, sticky per-frame flag for a malformed line.

Function
REQ-014 The block SHALL register cmos_data, cmos_href and cmos_vsync once on input (stage s1); all decisions use s1 values.
REQ-015 The FSM SHALL use three states.
- IDLE: entered on reset; goes to SKIP on the first s1 vsync rising edge, with skip_cnt = 1.
- SKIP: each further vsync rising edge increments skip_cnt.
- RUN: entered on the vsync rising edge at which skip_cnt would exceed FRAME_SKIP; stays there until reset.
REQ-016 With FRAME_SKIP = 0, the FSM SHALL enter RUN at the first vsync rising edge. A partial frame in progress at reset release SHALL never be output.
REQ-017 While s1 href = 1, a byte-phase bit SHALL toggle every cycle.
- Phase 0: latch the byte.
- Phase 1: combine the latched byte with the current byte, ordered per HI_FIRST, to complete a pixel.
REQ-018 The phase bit SHALL clear whenever s1 href = 0. A dangling half pixel at href fall SHALL be discarded and never emitted.
REQ-019 In RUN, each completed pixel SHALL produce pdata_o and a de_o pulse exactly one cycle after the phase-1 byte is in s1. Latency from the cmos_data pin to de_o is 2 cycles.
REQ-020 Outside RUN, de_o SHALL be 0 and pdata_o SHALL hold its previous value.
REQ-021 vs_o SHALL equal s1 vsync delayed 1 cycle, in every state, so downstream vsync edge detection stays aligned.
REQ-022 de_o SHALL never be high in consecutive cycles. The maximum rate is one pixel per 2 clocks.
REQ-023 A 12-bit pixel counter SHALL count completed pixels per line. It clears on href falling edge and saturates at 4095.
REQ-024 On href falling edge in RUN, line_err SHALL be set if the phase bit = 1 (odd byte count) or the pixel count ≠ H_PIX.
REQ-025 line_err SHALL clear on each vsync rising edge. If a set and a clear occur in the same cycle, the clear wins.
REQ-026 frame_cnt SHALL increment modulo 256 on each vsync rising edge while in RUN, including the entry edge.
REQ-027 If vsync rises while href = 1, the line SHALL be truncated: phase cleared, pixel counter cleared, no line_err for that line.

Reset
REQ-028 Asynchronous assertion of rst_n low SHALL force the following, regardless of pixel_clk:
- state = IDLE; skip_cnt, phase and pixel counter = 0; s1 registers = 0.
- pdata_o = 0, de_o = 0, vs_o = 0, frame_cnt = 0, line_err = 0.
REQ-029 Reset release SHALL be usable mid-frame: behaviour restarts per REQ-015/016 with no output before the next qualifying vsync edge.

Structure
REQ-030 The FSM state encoding and the RGB565 field widths (5/6/5) SHALL live in the shared video package, alongside the other pixel-format constants.
REQ-031 The block SHALL be a single module with no sub-modules. The byte pairing is too small to justify a separate instance.

Verification
REQ-032 Reset mid-frame, FRAME_SKIP = 2, 3 frames of 4 lines × 8 bytes (H_PIX = 4) -> de_o pulses only in frame 3, 16 pulses total, frame_cnt = 1.
REQ-033 Bytes 0xF8, 0x1F with HI_FIRST = 1 -> pdata_o = 16'hF81F, de_o high 2 cycles after the second byte; HI_FIRST = 0 -> 16'h1FF8.
REQ-034 A line of 7 bytes (H_PIX = 4) -> 3 pixels out, line_err = 1 after href falls, line_err = 0 after the next vsync rise.
REQ-035 vsync rising while href = 1 mid-line -> no line_err, next frame's first pixel correct, vs_o rises exactly 2 cycles after the pin.
REQ-036 FRAME_SKIP = 0, 300 frames -> frame_cnt wraps 255 → 0 and ends at 44; de_o never high in two adjacent cycles.

Source files
------------

// File: rtl/cmos_capture_16b_pkg.sv
// Shared video definitions: capture FSM encoding and RGB565 pixel format.
package cmos_capture_16b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2
  } cap_state_t;

  localparam int R_W    = 5;
  localparam int G_W    = 6;
  localparam int B_W    = 5;
  localparam int PIX_W  = R_W + G_W + B_W;
  localparam int BYTE_W = 8;
  localparam int PCNT_W = 12;
  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;

  // Join the two DVP bytes of a pixel; hi_first selects which byte is [15:8].
  function automatic logic [PIX_W-1:0] pack_pair(input logic [BYTE_W-1:0] first,
                                                 input logic [BYTE_W-1:0] second,
                                                 input logic hi_first);
    return hi_first ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/cmos_capture_16b.sv
// DVP 8-bit to RGB565 capture: input register stage, frame-skip FSM,
// byte pairing, per-line length check and frame counting.
module cmos_capture_16b
  import cmos_capture_16b_pkg::*;
#(
  parameter int FRAME_SKIP = 10,
  parameter int H_PIX      = 640,
  parameter bit HI_FIRST   = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [7:0]  cmos_data,
  input  logic        cmos_href,
  input  logic        cmos_vsync,
  output logic [15:0] pdata_o,
  output logic        de_o,
  output logic        vs_o,
  output logic [7:0]  frame_cnt,
  output logic        line_err
);

  logic [BYTE_W-1:0] data_s1, byte_lat;
  logic              href_s1, vsync_s1, href_d;
  logic              phase, trunc;
  logic [PCNT_W-1:0] pix_cnt;
  logic [7:0]        skip_cnt, skip_nxt;
  cap_state_t        state, state_nxt;
  logic              vs_rise, href_fall, pix_done;

  // vs_o is s1 vsync delayed once, so it doubles as the edge-detect history.
  assign vs_rise   = vsync_s1 & ~vs_o;
  assign href_fall = href_d & ~href_s1;
  // A pair landing on the vsync edge belongs to a truncated line and is dropped.
  assign pix_done  = href_s1 & phase & ~vs_rise;

  // Input stage: every decision below looks only at these registered copies.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1  <= '0;
      href_s1  <= 1'b0;
      vsync_s1 <= 1'b0;
      href_d   <= 1'b0;
    end else begin
      data_s1  <= cmos_data;
      href_s1  <= cmos_href;
      vsync_s1 <= cmos_vsync;
      href_d   <= href_s1;
    end
  end

  // State register for the skip/run sequencer.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  // Next state: count vsync edges until FRAME_SKIP whole frames have passed.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    case (state)
      ST_IDLE: if (vs_rise) begin
        if (FRAME_SKIP == 0) state_nxt = ST_RUN;
        else begin
          state_nxt = ST_SKIP;
          skip_nxt  = 8'd1;
        end
      end
      ST_SKIP: if (vs_rise) begin
        if (int'(skip_cnt) >= FRAME_SKIP) state_nxt = ST_RUN;
        else skip_nxt = skip_cnt + 8'd1;
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Byte pairing: phase 0 latches, phase 1 completes; any gap or vsync edge realigns.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 1'b0;
      byte_lat <= '0;
    end else begin
      if (!href_s1 || vs_rise) phase <= 1'b0;
      else                     phase <= ~phase;
      if (href_s1 && !phase) byte_lat <= data_s1;
    end
  end

  // Per-line pixel count (saturating) and truncated-line marker.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      trunc   <= 1'b0;
    end else begin
      if (href_fall || vs_rise)              pix_cnt <= '0;
      else if (pix_done && pix_cnt != PCNT_MAX) pix_cnt <= pix_cnt + 1'b1;
      if (vs_rise && href_s1) trunc <= 1'b1;
      else if (href_fall)     trunc <= 1'b0;
    end
  end

  // Pixel output: one cycle after the completing byte, only while running.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      pdata_o <= '0;
      de_o    <= 1'b0;
      vs_o    <= 1'b0;
    end else begin
      vs_o <= vsync_s1;
      de_o <= pix_done && (state == ST_RUN);
      if (pix_done && state == ST_RUN) pdata_o <= pack_pair(byte_lat, data_s1, HI_FIRST);
    end
  end

  // Frame counter and sticky line error; the vsync clear beats a same-cycle set.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      line_err  <= 1'b0;
    end else begin
      if (vs_rise && state_nxt == ST_RUN) frame_cnt <= frame_cnt + 8'd1;
      if (vs_rise) line_err <= 1'b0;
      else if (href_fall && state == ST_RUN && !trunc &&
               (phase || pix_cnt != PCNT_W'(H_PIX)))
        line_err <= 1'b1;
    end
  end

endmodule
